// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant owners and
// the width of the fixed-latency wait counter.
package mem_port_arbiter_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_F    = 2'd1,
        GNT_D    = 2'd2,
        GNT_L    = 2'd3
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection among fetch, data and loader requests.
// A starved fetch jumps ahead of data but never ahead of the loader.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   f_req,
    input  logic   d_req,
    input  logic   l_req,
    input  logic   starved,
    output grant_e gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (l_req)
            gnt = GNT_L;
        else if (f_req && starved)
            gnt = GNT_F;
        else if (d_req)
            gnt = GNT_D;
        else if (f_req)
            gnt = GNT_F;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch, data and loader accesses onto the single memory port:
// IDLE -> ISSUE -> (WAIT) -> RESP, one access outstanding at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant_id
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [DW-1:0]     f_rdata_q, f_rdata_d;
    logic [DW-1:0]     d_rdata_q, d_rdata_d;

    grant_e pick;
    logic   starved;
    logic   capture;

    assign starved = (starve_q == STARVE_LIM);

    arb_pick u_pick (
        .f_req   (f_req),
        .d_req   (d_req),
        .l_req   (l_req),
        .starved (starved),
        .gnt     (pick)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        capture   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Fetch losing while it asks counts toward starvation; any
                // idle sample without a fetch request forgives the history.
                if (!f_req || pick == GNT_F)
                    starve_d = '0;
                else if (!starved)
                    starve_d = starve_q + 1'b1;

                if (pick != GNT_NONE) begin
                    grant_d = pick;
                    state_d = ST_ISSUE;
                    case (pick)
                        GNT_F: begin
                            addr_d  = f_addr;
                            we_d    = 1'b0;
                            wdata_d = '0;
                        end
                        GNT_D: begin
                            addr_d  = d_addr;
                            we_d    = d_we;
                            wdata_d = d_wdata;
                        end
                        default: begin
                            addr_d  = l_addr;
                            we_d    = l_we;
                            wdata_d = l_wdata;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_W'(MEM_LAT - 1);
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase

        // Read data lands in the owner's register on the edge entering RESP;
        // stores and loader reads leave both registers untouched.
        if (capture && !we_q) begin
            if (grant_q == GNT_F)
                f_rdata_d = mem_rdata;
            else if (grant_q == GNT_D)
                d_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= GNT_NONE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_q     <= '0;
            starve_q  <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign f_ack     = (state_q == ST_RESP) && (grant_q == GNT_F);
    assign d_ack     = (state_q == ST_RESP) && (grant_q == GNT_D);
    assign l_ack     = (state_q == ST_RESP) && (grant_q == GNT_L);
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts each grant, memory
// strobe and ack; a monitor compares whenever the DUT strobes or acks.
module tb_mem_port_arbiter;

    localparam int AW = 32, DW = 32, LAT = 2, SMAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          f_req, d_req, d_we, l_req, l_we;
    logic [AW-1:0] f_addr, d_addr, l_addr;
    logic [DW-1:0] d_wdata, l_wdata;
    logic          f_ack, d_ack, l_ack, mem_en, mem_we, busy;
    logic [DW-1:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant_id;

    // second instance exercises the no-WAIT path
    logic          f1_req, zb;
    logic [AW-1:0] f1_addr, za;
    logic [DW-1:0] zd, mem1_rdata;
    logic          f1_ack, d1_ack, l1_ack, mem1_en, mem1_we, busy1;
    logic [DW-1:0] f1_rdata, d1_rdata, mem1_wdata;
    logic [AW-1:0] mem1_addr;
    logic [1:0]    gid1;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
        .clk(clk), .reset(reset),
        .f_req(f1_req), .f_addr(f1_addr), .f_ack(f1_ack), .f_rdata(f1_rdata),
        .d_req(zb), .d_we(zb), .d_addr(za), .d_wdata(zd),
        .d_ack(d1_ack), .d_rdata(d1_rdata),
        .l_req(zb), .l_we(zb), .l_addr(za), .l_wdata(zd), .l_ack(l1_ack),
        .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
        .mem_rdata(mem1_rdata), .busy(busy1), .grant_id(gid1)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i * 17);
    endfunction

    // memory seen by the DUT
    logic [31:0] dmem [128];
    assign mem_rdata = dmem[mem_addr[6:0]];
    initial begin
        for (int i = 0; i < 128; i++) dmem[i] = init_word(i);
        dmem[16] = 32'h2008000A;
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1 && mem_we === 1'b1) dmem[mem_addr[6:0]] = mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          id;
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] f_exp;
        logic [31:0] d_exp;
    } exp_t;
    exp_t q_mem[$];
    exp_t q_ack[$];

    // reference model state: memory contents, starvation history, last reads
    logic [31:0] mmem [128];
    int          starve_m;
    logic [31:0] f_last, d_last;
    bit          after_ack;
    bit          pend [4];
    logic        we_p [4];
    logic [31:0] addr_p [4];
    logic [31:0] wdata_p [4];

    initial begin : monitor
        exp_t e;
        int   got, nacks;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_en === 1'b1) begin
                    total++;
                    if (q_mem.size() == 0) begin
                        bad++;
                        $display("FAIL mem_en_unexpected: strobe at cyc %0d, required none", cyc);
                    end else begin
                        e = q_mem.pop_front();
                        if (cyc != e.cyc || mem_addr !== e.addr || mem_we !== e.we ||
                            (e.we && mem_wdata !== e.wdata) || busy !== 1'b1) begin
                            bad++;
                            $display("FAIL mem_access: cyc=%0d addr=%h we=%b wdata=%h busy=%b, required cyc=%0d addr=%h we=%b wdata=%h busy=1",
                                     cyc, mem_addr, mem_we, mem_wdata, busy, e.cyc, e.addr, e.we, e.wdata);
                        end
                    end
                end
                if (f_ack === 1'b1 || d_ack === 1'b1 || l_ack === 1'b1) begin
                    total++;
                    nacks = int'(f_ack) + int'(d_ack) + int'(l_ack);
                    got   = f_ack ? 1 : (d_ack ? 2 : 3);
                    if (q_ack.size() == 0) begin
                        bad++;
                        $display("FAIL ack_unexpected: ack from %0d at cyc %0d, required none", got, cyc);
                    end else begin
                        e = q_ack.pop_front();
                        if (nacks != 1 || got != e.id || cyc != e.cyc + LAT ||
                            int'(grant_id) != e.id || f_rdata !== e.f_exp || d_rdata !== e.d_exp) begin
                            bad++;
                            $display("FAIL ack: id=%0d n=%0d cyc=%0d gnt=%0d f_rdata=%h d_rdata=%h, required id=%0d n=1 cyc=%0d gnt=%0d f_rdata=%h d_rdata=%h",
                                     got, nacks, cyc, grant_id, f_rdata, d_rdata,
                                     e.id, e.cyc + LAT, e.id, e.f_exp, e.d_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_pins();
        f_req = pend[1]; f_addr = addr_p[1];
        d_req = pend[2]; d_we = we_p[2]; d_addr = addr_p[2]; d_wdata = wdata_p[2];
        l_req = pend[3]; l_we = we_p[3]; l_addr = addr_p[3]; l_wdata = wdata_p[3];
    endtask

    task automatic raise(input int id, input logic we, input logic [31:0] a, input logic [31:0] w);
        pend[id]    = 1'b1;
        we_p[id]    = (id == 1) ? 1'b0 : we;
        addr_p[id]  = a;
        wdata_p[id] = (id == 1) ? 32'h0 : w;
        drive_pins();
    endtask

    function automatic int model_pick();
        if (pend[3]) return 3;
        if (pend[1] && starve_m == SMAX) return 1;
        if (pend[2]) return 2;
        if (pend[1]) return 1;
        return 0;
    endfunction

    // Predict the next arbitration from the pending set; called at a negedge.
    task automatic issue(output int w, output int sc);
        exp_t e;
        w  = model_pick();
        sc = 0;
        if (w == 0) begin
            starve_m = 0;
            return;
        end
        if (!pend[1] || w == 1) starve_m = 0;
        else if (starve_m < SMAX) starve_m++;
        sc      = cyc + (after_ack ? 2 : 1);
        e.id    = w;
        e.cyc   = sc;
        e.we    = we_p[w];
        e.addr  = addr_p[w];
        e.wdata = wdata_p[w];
        if (we_p[w]) mmem[addr_p[w][6:0]] = wdata_p[w];
        else if (w == 1) f_last = mmem[addr_p[w][6:0]];
        else if (w == 2) d_last = mmem[addr_p[w][6:0]];
        e.f_exp = f_last;
        e.d_exp = d_last;
        q_mem.push_back(e);
        q_ack.push_back(e);
    endtask

    task automatic run_round(output int w, output int dut_id);
        int sc;
        bit got;
        dut_id = 0;
        issue(w, sc);
        if (w == 0) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || grant_id !== 2'd0) begin
                bad++;
                $display("FAIL idle: busy=%b grant_id=%0d, required 0 0", busy, grant_id);
            end
            after_ack = 1'b0;
            return;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (f_ack === 1'b1 || d_ack === 1'b1 || l_ack === 1'b1);
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: no ack in 40 cycles, required ack for %0d", w);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        dut_id    = f_ack ? 1 : (d_ack ? 2 : 3);
        pend[w]   = 1'b0;
        drive_pins();
        after_ack = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 32'h40;
        return 32'($urandom_range(0, 15));
    endfunction

    initial begin : driver
        int w, g, sc, fwin;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0; we_p[i] = 1'b0; addr_p[i] = '0; wdata_p[i] = '0;
        end
        drive_pins();
        f1_req = 1'b0; f1_addr = '0; zb = 1'b0; za = '0; zd = '0;
        mem1_rdata = 32'h1234ABCD;
        for (int i = 0; i < 128; i++) mmem[i] = init_word(i);
        mmem[16] = 32'h2008000A;
        f_last = '0; d_last = '0; starve_m = 0; after_ack = 1'b0;

        repeat (2) @(negedge clk);
        total++;
        if ({f_ack, d_ack, l_ack, mem_en, mem_we, busy} !== 6'b0 || grant_id !== 2'd0 ||
            mem_addr !== '0 || mem_wdata !== '0 || f_rdata !== '0 || d_rdata !== '0) begin
            bad++;
            $display("FAIL reset_state: acks/en/we/busy=%b gnt=%0d addr=%h f=%h d=%h, required all 0",
                     {f_ack, d_ack, l_ack, mem_en, mem_we, busy}, grant_id, mem_addr, f_rdata, d_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // single fetch, then store/load round trip at 0x40
        raise(1, 1'b0, 32'h10, 32'h0);           run_round(w, g);
        raise(2, 1'b1, 32'h40, 32'hDEADBEEF);    run_round(w, g);
        raise(2, 1'b0, 32'h40, 32'h0);           run_round(w, g);
        total++;
        if (d_rdata !== 32'hDEADBEEF || f_rdata !== 32'h2008000A) begin
            bad++;
            $display("FAIL store_load: d_rdata=%h f_rdata=%h, required DEADBEEF 2008000A", d_rdata, f_rdata);
        end

        // all three at once
        raise(1, 1'b0, 32'h3, 32'h0);
        raise(2, 1'b0, 32'h4, 32'h0);
        raise(3, 1'b1, 32'h5, 32'h55AA55AA);
        for (int r = 0; r < 3; r++) run_round(w, g);

        // data held continuously against a waiting fetch
        raise(1, 1'b0, 32'h8, 32'h0);
        raise(2, 1'b0, 32'h9, 32'h0);
        fwin = 0;
        for (int r = 1; r <= 7 && fwin == 0; r++) begin
            run_round(w, g);
            if (g == 1) fwin = r;
            else if (!pend[2]) raise(2, 1'(r), 32'h9, 32'(r * 3));
        end
        total++;
        if (fwin != 5) begin
            bad++;
            $display("FAIL starvation: fetch granted on arbitration %0d, required 5", fwin);
        end

        for (int n = 0; n < 150; n++) begin
            for (int id = 1; id <= 3; id++)
                if (!pend[id] && $urandom_range(0, 2) == 0)
                    raise(id, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            run_round(w, g);
        end
        while (pend[1] || pend[2] || pend[3]) run_round(w, g);

        // reset while the fetch sits in WAIT
        raise(1, 1'b0, 32'h6, 32'h0);
        issue(w, sc);
        for (int i = 0; i < 10 && cyc != sc + 1; i++) @(negedge clk);
        total++;
        if (busy !== 1'b1 || mem_en !== 1'b0 || f_ack !== 1'b0) begin
            bad++;
            $display("FAIL wait_state: busy=%b mem_en=%b f_ack=%b, required 1 0 0", busy, mem_en, f_ack);
        end
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({f_ack, d_ack, l_ack, mem_en, mem_we, busy} !== 6'b0 || grant_id !== 2'd0 ||
            mem_addr !== '0 || mem_wdata !== '0 || f_rdata !== '0 || d_rdata !== '0) begin
            bad++;
            $display("FAIL async_reset: acks/en/we/busy=%b gnt=%0d addr=%h f=%h d=%h, required all 0",
                     {f_ack, d_ack, l_ack, mem_en, mem_we, busy}, grant_id, mem_addr, f_rdata, d_rdata);
        end
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        drive_pins();
        q_mem.delete(); q_ack.delete();
        starve_m = 0; f_last = '0; d_last = '0; after_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_idle: busy=%b grant_id=%0d, required 0 0", busy, grant_id);
        end
        raise(1, 1'b0, 32'h10, 32'h0); run_round(w, g);
        raise(2, 1'b0, 32'h40, 32'h0); run_round(w, g);

        // single-cycle latency instance: ISSUE then straight to RESP
        @(negedge clk);
        f1_req = 1'b1; f1_addr = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (mem1_en !== (i == 1) || f1_ack !== (i == 2) || busy1 !== (i <= 2) ||
                int'(gid1) != ((i <= 2) ? 1 : 0) || d1_ack !== 1'b0 || l1_ack !== 1'b0 ||
                mem1_we !== 1'b0 || d1_rdata !== '0 || (i == 1 && mem1_addr !== '0) ||
                (i == 2 && f1_rdata !== 32'h1234ABCD)) begin
                bad++;
                $display("FAIL lat1 step %0d: en=%b ack=%b busy=%b gnt=%0d rdata=%h, required en=%b ack=%b busy=%b",
                         i, mem1_en, f1_ack, busy1, gid1, f1_rdata, i == 1, i == 2, i <= 2);
            end
            if (f1_ack === 1'b1) f1_req = 1'b0;
        end

        @(negedge clk);
        total++;
        if (q_mem.size() != 0 || q_ack.size() != 0) begin
            bad++;
            $display("FAIL leftover: mem=%0d ack=%0d expected events outstanding, required 0 0",
                     q_mem.size(), q_ack.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
